// File: rtl/parallel2serial.sv
// MSB-first parallel-to-serial converter; a word accepted at edge N shows its MSB after edge N.
// Holds all state while serial_ready is low; takes the next word only in the last-bit transfer cycle, so back-to-back words leave no gap.
module parallel2serial #(
    parameter int WIDTH = 2
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic [WIDTH-1:0] parallel_sig,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    output logic             serial_sig,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             first_sig,
    output logic             busy_sig
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_SHIFT  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_first;

    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    assign w_last    = (r_cnt == LAST_CNT);
    assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};

    // In SHIFT a new word is only taken while the final bit is leaving.
    assign parallel_ready = !reset_sig && ((r_state == S_IDLE) || (serial_ready && w_last));
    assign w_accept       = parallel_valid && parallel_ready;

    assign serial_sig   = r_shreg[WIDTH-1];
    assign serial_valid = (r_state == S_SHIFT);
    assign busy_sig     = (r_state == S_SHIFT);
    assign first_sig    = r_first;

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_shreg <= parallel_sig;
                r_cnt   <= '0;
                r_first <= 1'b1;
                r_state <= S_SHIFT;
            end
        end else if (serial_ready) begin
            if (!w_last) begin
                r_shreg <= w_shifted;
                r_cnt   <= r_cnt + 1'b1;
                r_first <= 1'b0;
            end else if (w_accept) begin
                r_shreg <= parallel_sig;
                r_cnt   <= '0;
                r_first <= 1'b1;
            end else begin
                r_shreg <= w_shifted;
                r_first <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_parallel2serial.sv
// Bench for parallel2serial at WIDTH 2, 4 and 8: a remaining-bits model checked every cycle,
// directed scenarios with literal expectations, and a random loopback through a serial-to-parallel shifter.
module tb_parallel2serial;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] pd [3];
    logic [2:0] pv, sr, pr, ss, sv, fs, bz;

    parallel2serial #(.WIDTH(2)) u_w2 (
        .clk_sig(clk), .reset_sig(rst), .parallel_sig(pd[0][1:0]), .parallel_valid(pv[0]),
        .parallel_ready(pr[0]), .serial_sig(ss[0]), .serial_valid(sv[0]), .serial_ready(sr[0]),
        .first_sig(fs[0]), .busy_sig(bz[0]));
    parallel2serial #(.WIDTH(4)) u_w4 (
        .clk_sig(clk), .reset_sig(rst), .parallel_sig(pd[1][3:0]), .parallel_valid(pv[1]),
        .parallel_ready(pr[1]), .serial_sig(ss[1]), .serial_valid(sv[1]), .serial_ready(sr[1]),
        .first_sig(fs[1]), .busy_sig(bz[1]));
    parallel2serial #(.WIDTH(8)) u_w8 (
        .clk_sig(clk), .reset_sig(rst), .parallel_sig(pd[2]), .parallel_valid(pv[2]),
        .parallel_ready(pr[2]), .serial_sig(ss[2]), .serial_valid(sv[2]), .serial_ready(sr[2]),
        .first_sig(fs[2]), .busy_sig(bz[2]));

    int         nchk = 0;
    int         nerr = 0;
    int         W [3] = '{2, 4, 8};
    int         mleft [3] = '{0, 0, 0};
    logic [7:0] mword [3];
    logic [7:0] src_q [$];
    logic [7:0] lb_sh = 8'h00;
    int         lb_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // A word can enter when nothing is pending, or when the single remaining bit leaves now.
    function automatic logic exp_rdy(input int k);
        return !rst && (mleft[k] == 0 || (sr[k] && mleft[k] == 1));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) mleft[k] = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic acc;
                acc = pv[k] && exp_rdy(k);
                if (mleft[k] > 0 && sr[k]) mleft[k]--;
                if (acc) begin
                    mword[k] = pd[k];
                    mleft[k] = W[k];
                    if (k == 2) src_q.push_back(pd[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ready%0d", k), {31'd0, pr[k]}, {31'd0, exp_rdy(k)});
            chk($sformatf("valid%0d", k), {31'd0, sv[k]}, (mleft[k] > 0) ? 1 : 0);
            chk($sformatf("busy%0d", k),  {31'd0, bz[k]}, (mleft[k] > 0) ? 1 : 0);
            if (mleft[k] > 0) begin
                int idx;
                idx = mleft[k] - 1;
                chk($sformatf("bit%0d", k),   {31'd0, ss[k]}, {31'd0, mword[k][idx]});
                chk($sformatf("first%0d", k), {31'd0, fs[k]}, (mleft[k] == W[k]) ? 1 : 0);
            end
        end
        if (rst) begin
            lb_cnt = 0;
            lb_sh  = 8'h00;
        end else if (sv[2] && sr[2]) begin
            lb_sh = {lb_sh[6:0], ss[2]};
            lb_cnt++;
            if (lb_cnt == 8) begin
                lb_cnt = 0;
                if (src_q.size() == 0) chk("loopback_extra_word", 32'(lb_sh), 32'hFFFF_FFFF);
                else chk("loopback_word", 32'(lb_sh), 32'(src_q.pop_front()));
            end
        end
    end

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, cycles;
        logic acc;
        rst = 1'b0; pv = '0; sr = '1;
        for (int k = 0; k < 3; k++) pd[k] = 8'h00;
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), {31'd0, sv[k]}, 0);
            chk($sformatf("rst_bit%0d", k),   {31'd0, ss[k]}, 0);
            chk($sformatf("rst_first%0d", k), {31'd0, fs[k]}, 0);
            chk($sformatf("rst_ready%0d", k), {31'd0, pr[k]}, 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // WIDTH=2, load 2'b10 from IDLE
        pd[0] = 8'h02; pv[0] = 1'b1;
        @(negedge clk) chk("t2_ready_idle", {31'd0, pr[0]}, 1);
        @(posedge clk); #1 pv[0] = 1'b0;
        @(negedge clk) begin chk("t2_b0", {31'd0, ss[0]}, 1); chk("t2_f0", {31'd0, fs[0]}, 1); chk("t2_v0", {31'd0, sv[0]}, 1); end
        @(negedge clk) begin chk("t2_b1", {31'd0, ss[0]}, 0); chk("t2_f1", {31'd0, fs[0]}, 0); chk("t2_v1", {31'd0, sv[0]}, 1); end
        @(negedge clk) chk("t2_v2", {31'd0, sv[0]}, 0);
        settle();

        // WIDTH=4, 4'hA then 4'h5 with valid held
        begin
            logic [7:0] exp_bits;
            exp_bits = 8'b1010_0101;
            pd[1] = 8'h0A; pv[1] = 1'b1;
            @(posedge clk); #1 pd[1] = 8'h05;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk($sformatf("t3_bit%0d", i), {31'd0, ss[1]}, {31'd0, exp_bits[7-i]});
                chk($sformatf("t3_valid%0d", i), {31'd0, sv[1]}, 1);
                if (i < 7) chk($sformatf("t3_ready%0d", i), {31'd0, pr[1]}, (i == 3) ? 1 : 0);
                if (i == 3) begin @(posedge clk); #1 pv[1] = 1'b0; end
            end
            @(negedge clk) chk("t3_idle", {31'd0, sv[1]}, 0);
        end
        settle();

        // WIDTH=4, 4'h9 stalled three cycles on bit index 1
        pd[1] = 8'h09; pv[1] = 1'b1;
        @(posedge clk); #1 pv[1] = 1'b0;
        @(negedge clk) begin chk("t4_b0", {31'd0, ss[1]}, 1); chk("t4_f0", {31'd0, fs[1]}, 1); end
        @(posedge clk); #1 sr[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_bit%0d", i), {31'd0, ss[1]}, 0);
            chk($sformatf("t4_stall_first%0d", i), {31'd0, fs[1]}, 0);
            chk($sformatf("t4_stall_valid%0d", i), {31'd0, sv[1]}, 1);
            @(posedge clk); #1;
        end
        sr[1] = 1'b1;
        @(negedge clk) chk("t4_b1", {31'd0, ss[1]}, 0);
        @(negedge clk) chk("t4_b2", {31'd0, ss[1]}, 0);
        @(negedge clk) chk("t4_b3", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t4_idle", {31'd0, sv[1]}, 0);
        settle();

        // WIDTH=4, second word presented early waits for the last-bit cycle
        pd[1] = 8'h0C; pv[1] = 1'b1;
        @(posedge clk); #1 pv[1] = 1'b0;
        @(negedge clk) chk("t5_b0", {31'd0, ss[1]}, 1);
        @(posedge clk); #1 begin pd[1] = 8'h03; pv[1] = 1'b1; end
        @(negedge clk) begin chk("t5_b1", {31'd0, ss[1]}, 1); chk("t5_r1", {31'd0, pr[1]}, 0); end
        @(negedge clk) begin chk("t5_b2", {31'd0, ss[1]}, 0); chk("t5_r2", {31'd0, pr[1]}, 0); end
        @(negedge clk) begin chk("t5_b3", {31'd0, ss[1]}, 0); chk("t5_r3", {31'd0, pr[1]}, 1); end
        @(posedge clk); #1 pv[1] = 1'b0;
        @(negedge clk) begin chk("t5_n0", {31'd0, ss[1]}, 0); chk("t5_nf0", {31'd0, fs[1]}, 1); chk("t5_nv0", {31'd0, sv[1]}, 1); end
        @(negedge clk) chk("t5_n1", {31'd0, ss[1]}, 0);
        @(negedge clk) chk("t5_n2", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t5_n3", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t5_idle", {31'd0, sv[1]}, 0);
        settle();

        // WIDTH=4, reset during bit index 2 of 4'hC, then 4'h3
        pd[1] = 8'h0C; pv[1] = 1'b1;
        @(posedge clk); #1 pv[1] = 1'b0;
        @(negedge clk) chk("t1_b0", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t1_b1", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t1_b2", {31'd0, ss[1]}, 0);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_valid", {31'd0, sv[1]}, 0);
        chk("t1_async_bit",   {31'd0, ss[1]}, 0);
        chk("t1_async_first", {31'd0, fs[1]}, 0);
        chk("t1_async_busy",  {31'd0, bz[1]}, 0);
        chk("t1_async_ready", {31'd0, pr[1]}, 0);
        @(posedge clk); #1 begin rst = 1'b0; pd[1] = 8'h03; pv[1] = 1'b1; end
        #1 chk("t1_ready_after", {31'd0, pr[1]}, 1);
        @(posedge clk); #1 pv[1] = 1'b0;
        @(negedge clk) begin chk("t1_n0", {31'd0, ss[1]}, 0); chk("t1_nf0", {31'd0, fs[1]}, 1); end
        @(negedge clk) chk("t1_n1", {31'd0, ss[1]}, 0);
        @(negedge clk) chk("t1_n2", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t1_n3", {31'd0, ss[1]}, 1);
        @(negedge clk) chk("t1_idle", {31'd0, sv[1]}, 0);
        settle();

        // WIDTH=8 loopback, random words and random serial_ready
        sent = 0; cycles = 0;
        pd[2] = 8'($urandom); pv[2] = 1'b1;
        while (sent < 1000 && cycles < 30000) begin
            @(posedge clk);
            acc = pv[2] && pr[2];
            #1;
            if (acc) begin
                sent++;
                if (sent < 1000) pd[2] = 8'($urandom);
                else pv[2] = 1'b0;
            end
            sr[2] = ($urandom_range(0, 3) != 0);
            cycles++;
        end
        chk("loopback_words_sent", 32'(sent), 32'd1000);
        pv[2] = 1'b0; sr[2] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("loopback_drained", 32'(src_q.size()), 32'd0);
        chk("loopback_partial", 32'(lb_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
